// File: rtl/daq_frame_reader_pkg.sv
// Shared DAQ frame definitions: frame sync word, words per frame, byte order,
// reader FSM state encoding and a helper that picks a preamble byte in stream order.
package daq_frame_reader_pkg;

   localparam logic [15:0] DAQ_PREAMBLE  = 16'hAAAA;
   localparam int          DAQ_ADCCOUNT  = 8;
   localparam bit          DAQ_LSB_FIRST = 1'b1;

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_HUNT2 = 2'd1,
      ST_DATA  = 2'd2,
      ST_PRE   = 2'd3
   } daq_state_e;

   // Byte of the preamble as it leaves the FIFO: second=0 is the first byte read.
   function automatic logic [7:0] pre_byte(input logic [15:0] pre, input bit lsb_first,
                                           input bit second);
      pre_byte = (lsb_first ^ second) ? pre[7:0] : pre[15:8];
   endfunction

endpackage

// File: rtl/daq_byte_assembler.sv
// Rebuilds 16-bit words from a byte stream.
//  clk_i, reset_i   block clock, async active-low reset
//  byte_vld         byte_data is valid this cycle
//  byte_data        incoming byte
//  phase            0: first byte of a word, 1: second byte
//  word / word_stb  assembled word, valid while word_stb=1 (second byte cycle)
module daq_byte_assembler #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        byte_vld,
   input  logic [7:0]  byte_data,
   input  logic        phase,
   output logic [15:0] word,
   output logic        word_stb
);

   logic [7:0] first_q;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)                 first_q <= '0;
      else if (byte_vld && !phase)  first_q <= byte_data;
   end

   // The word is formed combinationally in the second-byte cycle so the top
   // can register it straight into its output stage.
   assign word     = LSB_FIRST ? {byte_data, first_q} : {first_q, byte_data};
   assign word_stb = byte_vld && phase;

endmodule

// File: rtl/daq_frame_reader.sv
// Drains the 8-bit DAQ FIFO read side, locks onto the frame preamble, and
// streams 16-bit ADC samples tagged with their channel on a valid/ready port.
//  clk_i, reset_i          FIFO read clock, async active-low reset
//  en_i                    allow new frames (only acts between frames)
//  fifo_empty_i/rdreq_o    FIFO read handshake, data returns one cycle after rdreq
//  fifo_data_i             FIFO read data
//  sample_o/chan_o         sample and channel, qualified by sample_valid_o
//  sample_valid_o/ready_i  output handshake
//  frame_done_o            pulse when the last word of a frame loads
//  sync_err_o              pulse on an expected-preamble mismatch
//  frame_count_o           completed frames, wraps
module daq_frame_reader
   import daq_frame_reader_pkg::*;
#(
   parameter int          ADCCOUNT  = DAQ_ADCCOUNT,
   parameter logic [15:0] PREAMBLE  = DAQ_PREAMBLE,
   parameter bit          LSB_FIRST = DAQ_LSB_FIRST,
   parameter int          FCNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              en_i,
   input  logic              fifo_empty_i,
   output logic              fifo_rdreq_o,
   input  logic [7:0]        fifo_data_i,
   output logic [15:0]       sample_o,
   output logic [2:0]        chan_o,
   output logic              sample_valid_o,
   input  logic              sample_ready_i,
   output logic              frame_done_o,
   output logic              sync_err_o,
   output logic [FCNT_W-1:0] frame_count_o
);

   localparam logic [7:0] P1       = pre_byte(PREAMBLE, LSB_FIRST, 1'b0);
   localparam logic [7:0] P2       = pre_byte(PREAMBLE, LSB_FIRST, 1'b1);
   localparam logic [2:0] CH_LAST  = 3'(ADCCOUNT - 1);

   daq_state_e        state_q, state_d;
   logic              rd_pend_q;
   logic              ph_q, ph_d;        // phase of the next byte to arrive in DATA/PRE
   logic [2:0]        chan_q, chan_d;
   logic [15:0]       smp_d;
   logic [2:0]        ch_d;
   logic              vld_d, done_d, err_d;
   logic [FCNT_W-1:0] fcnt_d;
   logic [15:0]       word;
   logic              word_stb;
   logic              en_ok, stall;

   daq_byte_assembler #(.LSB_FIRST(LSB_FIRST)) u_asm (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .byte_vld  (rd_pend_q && (state_q == ST_DATA)),
      .byte_data (fifo_data_i),
      .phase     (ph_q),
      .word      (word),
      .word_stb  (word_stb)
   );

   // With at most one byte in flight, the byte being requested now is the 2nd
   // byte of a word exactly when rd_pend_q ^ ph_q in DATA. Holding that fetch
   // while the output is occupied means the load never collides with a stall.
   assign en_ok        = (state_q == ST_DATA) ? 1'b1 : en_i;
   assign stall        = (state_q == ST_DATA) && (rd_pend_q ^ ph_q) &&
                         sample_valid_o && !sample_ready_i;
   assign fifo_rdreq_o = reset_i && !fifo_empty_i && en_ok && !stall;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q        <= ST_HUNT;
         rd_pend_q      <= 1'b0;
         ph_q           <= 1'b0;
         chan_q         <= '0;
         sample_o       <= '0;
         chan_o         <= '0;
         sample_valid_o <= 1'b0;
         frame_done_o   <= 1'b0;
         sync_err_o     <= 1'b0;
         frame_count_o  <= '0;
      end else begin
         state_q        <= state_d;
         rd_pend_q      <= fifo_rdreq_o;
         ph_q           <= ph_d;
         chan_q         <= chan_d;
         sample_o       <= smp_d;
         chan_o         <= ch_d;
         sample_valid_o <= vld_d;
         frame_done_o   <= done_d;
         sync_err_o     <= err_d;
         frame_count_o  <= fcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      chan_d  = chan_q;
      smp_d   = sample_o;
      ch_d    = chan_o;
      vld_d   = sample_valid_o && !sample_ready_i;
      done_d  = 1'b0;
      err_d   = 1'b0;
      fcnt_d  = frame_count_o;
      if (rd_pend_q) begin
         unique case (state_q)
            ST_HUNT: if (fifo_data_i == P1) state_d = ST_HUNT2;
            ST_HUNT2: begin
               if (fifo_data_i == P2) begin
                  state_d = ST_DATA;
                  chan_d  = '0;
                  ph_d    = 1'b0;
               end else if (fifo_data_i != P1) begin
                  state_d = ST_HUNT;
               end
            end
            ST_DATA: begin
               ph_d = !ph_q;
               if (word_stb) begin
                  smp_d = word;
                  ch_d  = chan_q;
                  vld_d = 1'b1;
                  if (chan_q == CH_LAST) begin
                     done_d  = 1'b1;
                     fcnt_d  = frame_count_o + FCNT_W'(1);
                     chan_d  = '0;
                     state_d = ST_PRE;
                  end else begin
                     chan_d = chan_q + 3'd1;
                  end
               end
            end
            ST_PRE: begin
               if (!ph_q) begin
                  if (fifo_data_i == P1) ph_d = 1'b1;
                  else begin
                     err_d   = 1'b1;
                     state_d = ST_HUNT;
                  end
               end else begin
                  ph_d = 1'b0;
                  if (fifo_data_i == P2) begin
                     state_d = ST_DATA;
                     chan_d  = '0;
                  end else begin
                     err_d   = 1'b1;
                     state_d = (fifo_data_i == P1) ? ST_HUNT2 : ST_HUNT;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

endmodule
